// File: rtl/ff256ct_sched_pkg.sv
// Shared types for the FF256 cosine-transform issue scheduler.
package ff256ct_sched_pkg;

    // Tags carry the widest id a supported configuration (up to 8 requesters) can need.
    localparam int MAX_ID_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic                vld;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    function automatic int id_width(input int n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/ff256ct_rsp_fifo.sv
// First-word-fall-through response FIFO with occupancy count; output reads as zero while empty.
module ff256ct_rsp_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign do_pop   = pop && !empty;
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ff256ct_issue_sched.sv
// Round-robin issue scheduler sharing one FF256 cosine-transform engine between requesters,
// with credit-based issue so every in-flight result always has a response FIFO slot.
module ff256ct_issue_sched
    import ff256ct_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int CORE_LAT  = 1,
    parameter int RSP_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [64*N_REQ-1:0]         req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic [63:0]                 core_x_in,
    input  logic [63:0]                 core_x_out,
    output logic                        rsp_valid,
    output logic [63:0]                 rsp_data,
    output logic [$clog2(N_REQ)-1:0]    rsp_id,
    input  logic                        rsp_ready,
    output logic                        busy,
    output logic [$clog2(CORE_LAT+1):0] inflight
);

    localparam int ID_W   = id_width(N_REQ);
    localparam int CNT_W  = $clog2(RSP_DEPTH) + 1;
    localparam int INF_W  = $clog2(CORE_LAT + 1) + 1;
    localparam int FIFO_W = 64 + ID_W;

    sched_state_t      state;
    sched_state_t      state_next;
    logic              issue_ok;
    logic              has_credit;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   rr_ptr;
    logic              issue;
    logic [63:0]       sel_data;
    tag_t              tag_pipe [CORE_LAT];
    logic              fifo_push;
    logic [FIFO_W-1:0] fifo_wr_data;
    logic [FIFO_W-1:0] fifo_rd_data;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic              unused_tag_bits;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN waits for the tag pipe to empty; FIFO contents may still be pending.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (en) state_next = RUN;
            RUN:     if (!en) state_next = DRAIN;
            DRAIN: begin
                if (en) begin
                    state_next = RUN;
                end else if (inflight == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue_ok = (state == RUN);
    end

    // A pop this cycle only frees credit once fifo_count drops on the next edge.
    assign has_credit = (int'(fifo_count) + int'(inflight)) < RSP_DEPTH;

    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign issue = issue_ok && has_credit && grant_found;

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_data = req_data[64*i +: 64];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            core_x_in <= '0;
            inflight  <= '0;
            for (int s = 0; s < CORE_LAT; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            if (issue) begin
                rr_ptr    <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                core_x_in <= sel_data;
            end
            tag_pipe[0] <= '{vld: issue, id: MAX_ID_W'(grant_idx)};
            for (int s = 1; s < CORE_LAT; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end
            if (issue && !fifo_push) begin
                inflight <= inflight + INF_W'(1);
            end else if (!issue && fifo_push) begin
                inflight <= inflight - INF_W'(1);
            end
        end
    end

    assign fifo_push       = tag_pipe[CORE_LAT-1].vld;
    assign fifo_wr_data    = {core_x_out, tag_pipe[CORE_LAT-1].id[ID_W-1:0]};
    assign unused_tag_bits = ^tag_pipe[CORE_LAT-1].id;

    ff256ct_rsp_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_wr_data),
        .pop       (rsp_valid && rsp_ready),
        .pop_data  (fifo_rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = fifo_rd_data[FIFO_W-1:ID_W];
    assign rsp_id    = fifo_rd_data[ID_W-1:0];
    assign busy      = (state != IDLE) || (inflight != '0) || !fifo_empty;

    assert property (@(posedge clk) disable iff (!reset) fifo_push |-> !fifo_full);

endmodule

// File: tb/tb_ff256ct_issue_sched.sv
// Scoreboard bench for ff256ct_issue_sched: a CORE_LAT=1 instance for the main scenarios
// and a CORE_LAT=3 instance for pipelined back-to-back issue.
module tb_ff256ct_issue_sched;
    import ff256ct_sched_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  id;
        int          due;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total_checks = 0;
    int bad_checks   = 0;

    logic         en        = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [255:0] req_data  = '0;
    logic         rsp_ready = 1'b0;
    logic [3:0]   req_ready;
    logic [63:0]  core_x_in, core_x_out, rsp_data;
    logic         rsp_valid, busy;
    logic [1:0]   rsp_id;
    logic [1:0]   inflight;

    logic         en3        = 1'b0;
    logic [3:0]   req_valid3 = '0;
    logic [255:0] req_data3  = '0;
    logic         rsp_ready3 = 1'b0;
    logic [3:0]   req_ready3;
    logic [63:0]  core_x_in3, core_x_out3, rsp_data3;
    logic         rsp_valid3, busy3;
    logic [1:0]   rsp_id3;
    logic [2:0]   inflight3;
    logic [63:0]  stub_r0, stub_r1;

    exp_t exp_q[$];
    exp_t exp_q3[$];
    int   peak3 = 0;
    int   hs, hs3;
    logic [3:0] last_grant;

    // Engine stubs: bitwise NOT, delayed CORE_LAT-1 register stages.
    assign core_x_out = ~core_x_in;
    always @(posedge clk) begin
        stub_r0 <= ~core_x_in3;
        stub_r1 <= stub_r0;
    end
    assign core_x_out3 = stub_r1;

    ff256ct_issue_sched #(.N_REQ(4), .CORE_LAT(1), .RSP_DEPTH(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .core_x_in(core_x_in), .core_x_out(core_x_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
        .busy(busy), .inflight(inflight)
    );

    ff256ct_issue_sched #(.N_REQ(4), .CORE_LAT(3), .RSP_DEPTH(8)) dut_b (
        .clk(clk), .reset(reset), .en(en3), .req_valid(req_valid3), .req_data(req_data3),
        .req_ready(req_ready3), .core_x_in(core_x_in3), .core_x_out(core_x_out3),
        .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rsp_id(rsp_id3), .rsp_ready(rsp_ready3),
        .busy(busy3), .inflight(inflight3)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic en_v, input logic rdy);
        req_valid = valid;
        en        = en_v;
        rsp_ready = rdy;
    endtask

    task automatic do_reset();
        en = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 50 && busy; n++) tick();
        @(negedge clk);
        checkOutput(tag, busy, 0);
    endtask

    task automatic wait_drained(input string tag);
        for (int n = 0; n < 100 && (exp_q.size() != 0 || rsp_valid); n++) tick();
        checkOutput(tag, exp_q.size(), 0);
    endtask

    // Scoreboard A: expected results enqueued at each handshake, compared at each pop.
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back('{data: ~req_data[64*i +: 64], id: 2'(i), due: 0});
                end
            end
            if (rsp_valid && rsp_ready) begin
                checkOutput("a_rsp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("a_rsp_data", rsp_data, e.data);
                    checkOutput("a_rsp_id", rsp_id, e.id);
                end
            end
        end
    end

    // Scoreboard B also checks the cycle each result appears.
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                if (req_valid3[i] && req_ready3[i]) begin
                    exp_q3.push_back('{data: ~req_data3[64*i +: 64], id: 2'(i), due: cyc + 4});
                end
            end
            if (rsp_valid3 && rsp_ready3) begin
                checkOutput("b_rsp_expected", 64'(exp_q3.size() != 0), 64'd1);
                if (exp_q3.size() != 0) begin
                    exp_t e;
                    e = exp_q3.pop_front();
                    checkOutput("b_rsp_data", rsp_data3, e.data);
                    checkOutput("b_rsp_id", rsp_id3, e.id);
                    checkOutput("b_rsp_cycle", 64'(cyc), 64'(e.due));
                end
            end
            if (int'(inflight3) > peak3) peak3 = int'(inflight3);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #12;
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        checkOutput("rst_rsp_id", rsp_id, 0);
        checkOutput("rst_core_x_in", core_x_in, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_inflight", inflight, 0);
        checkOutput("rst_state", dut_a.state, IDLE);
        checkOutput("rst_rr_ptr", dut_a.rr_ptr, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        $display("[TB] single request");
        applyStimulus(4'b0000, 1'b1, 1'b1);
        tick();
        req_data[63:0] = 64'h0123456789ABCDEF;
        req_valid = 4'b0001;
        @(negedge clk);
        checkOutput("t1_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        @(negedge clk);
        checkOutput("t1_core_x_in", core_x_in, 64'h0123456789ABCDEF);
        checkOutput("t1_rsp_early", rsp_valid, 0);
        tick();
        @(negedge clk);
        checkOutput("t1_rsp_valid", rsp_valid, 1);
        checkOutput("t1_rsp_data", rsp_data, 64'hFEDCBA9876543210);
        checkOutput("t1_rsp_id", rsp_id, 0);
        tick();
        en = 1'b0;
        wait_idle("t1_busy_idle");

        $display("[TB] round-robin fairness");
        do_reset();
        for (int i = 0; i < 4; i++) req_data[64*i +: 64] = 64'hA5A5_0000_0000_0000 | 64'(i + 1);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        tick();
        req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("t2_grant", req_ready, 64'(1 << (c % 4)));
            tick();
        end
        req_valid = '0;
        wait_drained("t2_sb_empty");

        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        hs = 0;
        req_data[191:128] = 64'd1;
        req_valid = 4'b0100;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[2]) hs++;
            tick();
            req_data[191:128] = 64'(hs + 1);
        end
        checkOutput("t3_handshakes", hs, 8);
        @(negedge clk);
        checkOutput("t3_stalled", req_ready, 0);
        checkOutput("t3_head", rsp_data, ~64'd1);
        checkOutput("t3_inflight", inflight, 0);
        rsp_ready = 1'b1;
        for (int n = 0; n < 200 && hs < 20; n++) begin
            @(negedge clk);
            if (req_ready[2]) hs++;
            tick();
            if (hs == 20) req_valid = '0;
            else req_data[191:128] = 64'(hs + 1);
        end
        checkOutput("t3_all_issued", hs, 20);
        wait_drained("t3_sb_empty");

        $display("[TB] drain");
        req_data[127:64] = 64'h0F0F_1234_5678_9ABC;
        req_valid = 4'b0010;
        @(negedge clk);
        checkOutput("t4_grant", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        en = 1'b0;
        @(negedge clk);
        checkOutput("t4_inflight", inflight, 1);
        tick();
        req_valid = 4'b0010;
        @(negedge clk);
        checkOutput("t4_state_drain", dut_a.state, DRAIN);
        checkOutput("t4_no_grant_drain", req_ready, 0);
        tick();
        @(negedge clk);
        checkOutput("t4_state_idle", dut_a.state, IDLE);
        checkOutput("t4_no_grant_idle", req_ready, 0);
        req_valid = '0;
        wait_drained("t4_sb_empty");

        $display("[TB] reset mid-stream");
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick();
        hs = 0;
        req_data[255:192] = 64'h77;
        req_valid = 4'b1000;
        for (int n = 0; n < 20 && hs < 3; n++) begin
            @(negedge clk);
            if (req_ready[3]) hs++;
            tick();
            req_data[255:192] = 64'h77 + 64'(hs);
        end
        req_valid = '0;
        tick();
        tick();
        @(negedge clk);
        checkOutput("t5_fifo_count", dut_a.fifo_count, 3);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t5_rsp_valid", rsp_valid, 0);
        checkOutput("t5_inflight", inflight, 0);
        checkOutput("t5_core_x_in", core_x_in, 0);
        checkOutput("t5_busy", busy, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b1);
        tick();
        req_data[63:0] = 64'hDEAD_BEEF_CAFE_F00D;
        req_valid = 4'b0001;
        @(negedge clk);
        checkOutput("t5_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_drained("t5_sb_empty");

        $display("[TB] CORE_LAT=3 back-to-back");
        en3 = 1'b1;
        rsp_ready3 = 1'b1;
        req_data3[63:0]   = 64'h1111;
        req_data3[127:64] = 64'h2222;
        tick();
        req_valid3 = 4'b0011;
        hs3 = 0;
        for (int n = 0; n < 30 && hs3 < 6; n++) begin
            @(negedge clk);
            checkOutput("t6_b2b_grant", 64'(req_ready3 != 4'b0000), 64'd1);
            last_grant = req_ready3;
            if (req_ready3 != 4'b0000) hs3++;
            tick();
            for (int i = 0; i < 4; i++) begin
                if (last_grant[i]) req_data3[64*i +: 64] = req_data3[64*i +: 64] + 64'h100;
            end
        end
        req_valid3 = '0;
        for (int n = 0; n < 30 && (exp_q3.size() != 0 || rsp_valid3); n++) tick();
        checkOutput("t6_sb_empty", exp_q3.size(), 0);
        checkOutput("t6_inflight_peak", peak3, 3);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/ff256ct_issue_sched.md
Name: ff256ct_issue_sched

Overview:
- Round-robin scheduler sharing one FF256 cosine-transform engine (64-bit vector in, 64-bit vector out, fixed CORE_LAT) among N_REQ requesters.
- Arbitrates input vectors, tracks in-flight operations with a tag pipeline, and returns each result tagged with its requester id through a response FIFO.
- Credit-based issue means a result never has to be dropped.
- An enable/drain state machine lets software quiesce the engine before reconfiguration.

Parameters:
- N_REQ, 4, number of requester channels (2..8)
- CORE_LAT, 1, cycles from the core_x_in update edge to the edge where core_x_out is sampled (>=1)
- RSP_DEPTH, 8, response FIFO entries (power of 2, >= CORE_LAT+1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  1 = accept new requests; 0 = stop issuing and drain
- req_valid  in  N_REQ  per-requester vector valid
- req_data  in  64*N_REQ  vector of requester i is req_data[64*i+63:64*i]
- req_ready  out  N_REQ  one-hot grant; handshake on req_valid[i] & req_ready[i]
- core_x_in  out  64  registered operand to the transform engine
- core_x_out  in  64  engine result
- rsp_valid  out  1  FIFO head valid
- rsp_data  out  64  transformed vector
- rsp_id  out  $clog2(N_REQ)  originating requester
- rsp_ready  in  1  consumer pop
- busy  out  1  state != IDLE or in-flight count != 0 or FIFO not empty
- inflight  out  $clog2(CORE_LAT+1)+1  operations issued but not yet written to the FIFO

Behaviour:
- Reset values:
  - state = IDLE, rr_ptr = 0
  - core_x_in = 0, req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0
  - FIFO empty, tag pipe cleared, inflight = 0, busy = 0
- States:
  - IDLE: no issue; go to RUN when en = 1.
  - RUN: issue allowed; go to DRAIN when en = 0.
  - DRAIN: no issue; go to IDLE when inflight = 0. If en returns to 1 while in DRAIN, go straight to RUN.
- Credit:
  - free = RSP_DEPTH - fifo_count - inflight.
  - A pop in the same cycle is not credited until the next cycle (conservative).
  - Issue is allowed only when state = RUN and free > 0.
- Arbitration:
  - req_ready is combinational, one-hot. It selects the first i with req_valid[i] = 1, searching rr_ptr, rr_ptr+1, … modulo N_REQ.
  - req_ready is zero when issue is not allowed.
  - On a handshake for grant g: rr_ptr <= (g+1) mod N_REQ. rr_ptr is unchanged when there is no handshake.
- Issue at edge k:
  - core_x_in <= selected req_data; tag pipe stage 0 <= {valid = 1, id = g}.
  - core_x_in holds its value when there is no issue.
- Completion:
  - The tag pipe is CORE_LAT stages deep.
  - At edge k+CORE_LAT, core_x_out and the tag id are pushed into the FIFO.
  - Credit accounting guarantees the FIFO is never full at a push; an assertion checks this.
- inflight:
  - Counts valid tag stages: +1 on issue, -1 on push, unchanged when both occur.
- FIFO:
  - First-word-fall-through. rsp_valid = !empty.
  - Pop when rsp_valid & rsp_ready.
  - Simultaneous push and pop on a full or empty FIFO are both legal. Push into an empty FIFO is visible on the next cycle, with no bypass.
  - Order is strictly issue order.
- Throughput: one issue per cycle sustained when free > 0 and rsp_ready = 1.
- Reset mid-operation: all in-flight tags and FIFO contents are discarded. Requesters must re-submit.
- Upstream assumption: req_data is stable while req_valid is high and not yet granted.

Decomposition:
- Package ff256ct_sched_pkg:
  - state enum {IDLE, RUN, DRAIN}
  - tag struct {logic vld; logic [ID_W-1:0] id}
  - function computing ID_W from N_REQ
- Sub-module ff256ct_rsp_fifo: parameterized width and depth synchronous FIFO with count output. It holds the 64+ID_W wide entries.
- The arbiter stays inline.

Test Plan:
Bench core stub: core_x_out = bitwise NOT of core_x_in, delayed CORE_LAT-1 register stages after core_x_in. Defaults N_REQ = 4, CORE_LAT = 1, RSP_DEPTH = 8.
1. Single request:
   - Stimulus: en = 1, req_valid = 4'b0001, req_data[63:0] = 64'h0123456789ABCDEF, rsp_ready = 1.
   - Required: req_ready[0] in the same cycle; core_x_in updates at the next edge; rsp_valid 2 cycles after the handshake; rsp_data = 64'hFEDCBA9876543210, rsp_id = 0; busy returns to 0.
2. Round-robin fairness:
   - Stimulus: all four valid continuously, rr_ptr = 0.
   - Required: grant order 0,1,2,3,0,1; rsp_id sequence matches.
3. Backpressure:
   - Stimulus: rsp_ready = 0, requester 2 streams data = 1..20.
   - Required: exactly 8 handshakes then req_ready = 0; FIFO holds ~1..~8. Raising rsp_ready resumes issue, and data arrives in order without loss.
4. Drain:
   - Stimulus: en dropped with inflight = 1.
   - Required: no further req_ready; state DRAIN for 1 cycle then IDLE; the pending result is still delivered.
5. Reset mid-stream:
   - Stimulus: reset asserted with 3 entries in the FIFO.
   - Required: rsp_valid = 0, inflight = 0, core_x_in = 0 immediately (asynchronous); after release, a new request returns the correct result.
6. CORE_LAT = 3 build:
   - Stimulus: back-to-back issues.
   - Required: inflight peaks at 3; results arrive 4 cycles after their handshakes, one per cycle.
